// File: rtl/vx_alu_dotp_pipe.sv
// Packed int8/int4 dot-product unit with optional accumulate/saturate.
// Stage 1 registers per-element products; the sum, accumulate and clamp land in the first result stage.
module vx_alu_dotp_pipe #(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 32,
  parameter int LATENCY   = 2,
  parameter int TAG_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [1:0]                op_mode,
  input  logic                      op_acc,
  input  logic                      op_sat,
  input  logic [NUM_LANES*XLEN-1:0] a_in,
  input  logic [NUM_LANES*XLEN-1:0] b_in,
  input  logic [NUM_LANES*XLEN-1:0] c_in,
  input  logic [TAG_WIDTH-1:0]      tag_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [NUM_LANES*XLEN-1:0] data_out,
  output logic [NUM_LANES-1:0]      ovf_out,
  output logic [TAG_WIDTH-1:0]      tag_out
);

  localparam int W  = NUM_LANES * XLEN;
  localparam int RS = (LATENCY > 1) ? LATENCY - 1 : 1;

  typedef logic signed [17:0] prod_t;

  // valid/ready: a beat transfers on a cycle where valid && ready. The whole pipe
  // moves together and only when the output slot is empty or being drained.
  logic advance;
  logic accept;
  assign advance  = ready_out || !valid_out;
  assign ready_in = advance;
  assign accept   = valid_in && advance;

  // Element products; int8 uses slots 0..3 and leaves 4..7 at zero.
  prod_t       prod_in [NUM_LANES][8];
  logic [31:0] in_c    [NUM_LANES];

  always_comb begin
    logic [31:0]       x;
    logic [31:0]       y;
    logic signed [8:0] ea;
    logic signed [8:0] eb;
    x = '0;
    y = '0;
    ea = '0;
    eb = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      x = a_in[l*XLEN +: 32];
      y = b_in[l*XLEN +: 32];
      in_c[l] = c_in[l*XLEN +: 32];
      for (int k = 0; k < 8; k++) begin
        if (op_mode[1]) begin
          ea = op_mode[0] ? {5'b0, x[4*k +: 4]} : {{5{x[4*k+3]}}, x[4*k +: 4]};
          eb = op_mode[0] ? {5'b0, y[4*k +: 4]} : {{5{y[4*k+3]}}, y[4*k +: 4]};
        end else if (k < 4) begin
          ea = op_mode[0] ? {1'b0, x[8*(k%4) +: 8]} : {x[8*(k%4)+7], x[8*(k%4) +: 8]};
          eb = op_mode[0] ? {1'b0, y[8*(k%4) +: 8]} : {y[8*(k%4)+7], y[8*(k%4) +: 8]};
        end else begin
          ea = '0;
          eb = '0;
        end
        prod_in[l][k] = 18'(ea) * 18'(eb);
      end
    end
  end

  // Operands feeding the sum/accumulate/clamp logic.
  prod_t                fin_prod [NUM_LANES][8];
  logic [31:0]          fin_c    [NUM_LANES];
  logic                 fin_uns;
  logic                 fin_acc;
  logic                 fin_sat;
  logic [TAG_WIDTH-1:0] fin_tag;
  logic                 fin_vld;

  if (LATENCY > 1) begin : g_stage1
    prod_t                p1_prod [NUM_LANES][8];
    logic [31:0]          p1_c    [NUM_LANES];
    logic                 p1_uns;
    logic                 p1_acc;
    logic                 p1_sat;
    logic [TAG_WIDTH-1:0] p1_tag;
    logic                 p1_vld;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        p1_vld <= 1'b0;
        p1_uns <= 1'b0;
        p1_acc <= 1'b0;
        p1_sat <= 1'b0;
        p1_tag <= '0;
        for (int l = 0; l < NUM_LANES; l++) begin
          p1_c[l] <= '0;
          for (int k = 0; k < 8; k++) p1_prod[l][k] <= '0;
        end
      end else if (advance) begin
        p1_vld  <= accept;
        p1_uns  <= op_mode[0];
        p1_acc  <= op_acc;
        p1_sat  <= op_sat;
        p1_tag  <= tag_in;
        p1_c    <= in_c;
        p1_prod <= prod_in;
      end
    end

    assign fin_prod = p1_prod;
    assign fin_c    = p1_c;
    assign fin_uns  = p1_uns;
    assign fin_acc  = p1_acc;
    assign fin_sat  = p1_sat;
    assign fin_tag  = p1_tag;
    assign fin_vld  = p1_vld;
  end else begin : g_direct
    assign fin_prod = prod_in;
    assign fin_c    = in_c;
    assign fin_uns  = op_mode[0];
    assign fin_acc  = op_acc;
    assign fin_sat  = op_sat;
    assign fin_tag  = tag_in;
    assign fin_vld  = accept;
  end

  logic [W-1:0]         fin_data;
  logic [NUM_LANES-1:0] fin_ovf;

  // The 34-bit sum is exact, so overflow is just "upper bits are not a pure extension".
  always_comb begin
    logic signed [21:0] sum;
    logic [33:0]        cext;
    logic signed [33:0] r;
    logic [31:0]        r32;
    logic               o;
    logic [XLEN-1:0]    ext;
    sum = '0;
    cext = '0;
    r = '0;
    r32 = '0;
    o = 1'b0;
    ext = '0;
    fin_data = '0;
    fin_ovf = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      sum = '0;
      for (int k = 0; k < 8; k++) sum = sum + 22'(fin_prod[l][k]);
      cext = fin_uns ? {2'b00, fin_c[l]} : {{2{fin_c[l][31]}}, fin_c[l]};
      r = 34'(sum);
      if (fin_acc) r = r + $signed(cext);
      if (fin_uns) o = fin_acc && (r[33:32] != 2'b00);
      else         o = fin_acc && (r[33:31] != 3'b000) && (r[33:31] != 3'b111);
      r32 = r[31:0];
      if (o && fin_sat) r32 = fin_uns ? 32'hFFFF_FFFF : (r[33] ? 32'h8000_0000 : 32'h7FFF_FFFF);
      ext = {XLEN{!fin_uns && r32[31]}};
      ext[31:0] = r32;
      fin_data[l*XLEN +: XLEN] = ext;
      fin_ovf[l] = o;
    end
  end

  logic [W-1:0]         r_data [RS];
  logic [NUM_LANES-1:0] r_ovf  [RS];
  logic [TAG_WIDTH-1:0] r_tag  [RS];
  logic                 r_vld  [RS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RS; i++) begin
        r_data[i] <= '0;
        r_ovf[i]  <= '0;
        r_tag[i]  <= '0;
        r_vld[i]  <= 1'b0;
      end
    end else if (advance) begin
      r_data[0] <= fin_data;
      r_ovf[0]  <= fin_ovf;
      r_tag[0]  <= fin_tag;
      r_vld[0]  <= fin_vld;
      for (int i = 1; i < RS; i++) begin
        r_data[i] <= r_data[i-1];
        r_ovf[i]  <= r_ovf[i-1];
        r_tag[i]  <= r_tag[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
    end
  end

  assign valid_out = r_vld[RS-1];
  assign data_out  = r_data[RS-1];
  assign ovf_out   = r_ovf[RS-1];
  assign tag_out   = r_tag[RS-1];

endmodule

// File: tb/tb_vx_alu_dotp_pipe.sv
// Bench for vx_alu_dotp_pipe: directed table, backpressure, mid-flight reset,
// random traffic against an arithmetic model, and a 64-bit/latency-1 instance.
module tb_vx_alu_dotp_pipe;

  localparam int NL    = 4;
  localparam int XL    = 32;
  localparam int LAT   = 2;
  localparam int TW    = 8;
  localparam int W     = NL * XL;
  localparam int EXP_W = NL * 32 + NL + TW;
  localparam int NL64  = 2;
  localparam int W64   = NL64 * 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          valid_in, ready_in, op_acc, op_sat, valid_out, ready_out;
  logic [1:0]    op_mode;
  logic [W-1:0]  a_in, b_in, c_in, data_out;
  logic [NL-1:0] ovf_out;
  logic [TW-1:0] tag_in, tag_out;

  logic            v_valid_in, v_ready_in, v_op_acc, v_op_sat, v_valid_out, v_ready_out;
  logic [1:0]      v_op_mode;
  logic [W64-1:0]  v_a_in, v_b_in, v_c_in, v_data_out;
  logic [NL64-1:0] v_ovf_out;
  logic [TW-1:0]   v_tag_in, v_tag_out;

  always #5 clk = ~clk;

  vx_alu_dotp_pipe #(.NUM_LANES(NL), .XLEN(XL), .LATENCY(LAT), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready_in),
    .op_mode(op_mode), .op_acc(op_acc), .op_sat(op_sat),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .tag_in(tag_in),
    .valid_out(valid_out), .ready_out(ready_out),
    .data_out(data_out), .ovf_out(ovf_out), .tag_out(tag_out)
  );

  vx_alu_dotp_pipe #(.NUM_LANES(NL64), .XLEN(64), .LATENCY(1), .TAG_WIDTH(TW)) dut64 (
    .clk(clk), .reset_n(reset_n), .valid_in(v_valid_in), .ready_in(v_ready_in),
    .op_mode(v_op_mode), .op_acc(v_op_acc), .op_sat(v_op_sat),
    .a_in(v_a_in), .b_in(v_b_in), .c_in(v_c_in), .tag_in(v_tag_in),
    .valid_out(v_valid_out), .ready_out(v_ready_out),
    .data_out(v_data_out), .ovf_out(v_ovf_out), .tag_out(v_tag_out)
  );

  int checks = 0;
  int failures = 0;
  int out_cnt = 0;
  bit rnd_done = 1'b0;
  logic [EXP_W-1:0] exp_q[$];

  typedef struct packed {
    logic [1:0]  mode;
    logic        acc;
    logic        sat;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp_d;
    logic        exp_o;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [EXP_W-1:0] got, input logic [EXP_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference lane: plain integer arithmetic on the element values.
  function automatic logic [32:0] ref_lane(input logic [1:0] mode, input logic acc, input logic sat,
                                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    longint s, r, lo, hi, ea, eb;
    int n, w;
    logic sgn;
    logic o;
    logic [31:0] res;
    sgn = !mode[0];
    w = mode[1] ? 4 : 8;
    n = 32 / w;
    s = 0;
    for (int k = 0; k < n; k++) begin
      ea = longint'((a >> (k * w)) & ((32'd1 << w) - 1));
      eb = longint'((b >> (k * w)) & ((32'd1 << w) - 1));
      if (sgn && ea >= (longint'(1) << (w - 1))) ea = ea - (longint'(1) << w);
      if (sgn && eb >= (longint'(1) << (w - 1))) eb = eb - (longint'(1) << w);
      s = s + ea * eb;
    end
    if (!acc) return {1'b0, s[31:0]};
    r = s + (sgn ? longint'($signed(c)) : longint'(c));
    lo = sgn ? -(longint'(1) << 31) : 0;
    hi = sgn ? (longint'(1) << 31) - 1 : (longint'(1) << 32) - 1;
    o = (r < lo) || (r > hi);
    res = r[31:0];
    if (o && sat) res = (r < lo) ? 32'h8000_0000 : (sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF);
    return {o, res};
  endfunction

  function automatic logic [EXP_W-1:0] build_exp(input logic [1:0] mode, input logic acc, input logic sat,
                                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic [W-1:0] c, input logic [TW-1:0] tag);
    logic [W-1:0] d;
    logic [NL-1:0] o;
    logic [32:0] r;
    d = '0;
    o = '0;
    for (int l = 0; l < NL; l++) begin
      r = ref_lane(mode, acc, sat, a[l*32 +: 32], b[l*32 +: 32], c[l*32 +: 32]);
      d[l*32 +: 32] = r[31:0];
      o[l] = r[32];
    end
    return {d, o, tag};
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 4))
      0: return 32'h7F7F_7F7F;
      1: return 32'h8080_8080;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_c();
    case ($urandom_range(0, 3))
      0: return 32'h7FFF_F000 + $urandom_range(0, 'hFFF);
      1: return 32'hFFFF_F000 + $urandom_range(0, 'hFFF);
      2: return 32'h8000_0000 + $urandom_range(0, 'hFFF);
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: every visible result must match the queue head, held or consumed.
  always @(negedge clk) begin
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output got=%h tag=%h exp=none", data_out, tag_out);
      end else if (ready_out) begin
        check("result", {data_out, ovf_out, tag_out}, exp_q[0]);
        void'(exp_q.pop_front());
        out_cnt++;
      end else begin
        check("held_result", {data_out, ovf_out, tag_out}, exp_q[0]);
      end
    end
  end

  task automatic send(input logic [1:0] mode, input logic acc, input logic sat,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic [TW-1:0] tag, input logic [EXP_W-1:0] exp);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    valid_in = 1'b1;
    op_mode = mode;
    op_acc = acc;
    op_sat = sat;
    a_in = a;
    b_in = b;
    c_in = c;
    tag_in = tag;
    while (!got && n < 100) begin
      @(negedge clk);
      got = ready_in;
      @(posedge clk);
      #1;
      n++;
    end
    valid_in = 1'b0;
    check("send_accept", got, 1);
    if (got) exp_q.push_back(exp);
  endtask

  task automatic send_rand(input logic [TW-1:0] tag);
    logic [1:0] mode;
    logic acc, sat;
    logic [W-1:0] a, b, c;
    mode = 2'($urandom_range(0, 3));
    acc = 1'($urandom_range(0, 1));
    sat = 1'($urandom_range(0, 1));
    for (int l = 0; l < NL; l++) begin
      a[l*32 +: 32] = rand_op();
      b[l*32 +: 32] = rand_op();
      c[l*32 +: 32] = rand_c();
    end
    send(mode, acc, sat, a, b, c, tag, build_exp(mode, acc, sat, a, b, c, tag));
  endtask

  task automatic measure_latency(input string name);
    int k;
    k = 1;
    while (!valid_out && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, k, LAT);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send64(input string name, input logic [1:0] mode, input logic acc, input logic sat,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] c0,
                        input logic [63:0] exp0, input logic exp_o0);
    logic [31:0] a1, b1, c1;
    logic [32:0] r1;
    logic [63:0] e1;
    a1 = rand_op();
    b1 = rand_op();
    c1 = rand_c();
    r1 = ref_lane(mode, acc, sat, a1, b1, c1);
    e1 = mode[0] ? {32'h0, r1[31:0]} : {{32{r1[31]}}, r1[31:0]};
    @(posedge clk);
    #1;
    v_valid_in = 1'b1;
    v_op_mode = mode;
    v_op_acc = acc;
    v_op_sat = sat;
    v_a_in = {$urandom, a1, $urandom, a0};
    v_b_in = {$urandom, b1, $urandom, b0};
    v_c_in = {$urandom, c1, $urandom, c0};
    v_tag_in = 8'($urandom);
    @(negedge clk);
    check({name, "_ready"}, v_ready_in, 1);
    @(posedge clk);
    #1;
    v_valid_in = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, v_valid_out, 1);
    check({name, "_data"}, v_data_out, {e1, exp0});
    check({name, "_ovf"}, v_ovf_out, {r1[32], exp_o0});
    check({name, "_tag"}, v_tag_out, v_tag_in);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [W-1:0] a, b, c;
    logic [EXP_W-1:0] e;

    tbl[0]  = '{2'b00, 1'b0, 1'b0, 32'h0403_0201, 32'h0101_0101, 32'h0000_0000, 32'h0000_000A, 1'b0};
    tbl[1]  = '{2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0101_0101, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0};
    tbl[2]  = '{2'b01, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0101_0101, 32'h0000_0000, 32'h0000_03FC, 1'b0};
    tbl[3]  = '{2'b10, 1'b0, 1'b0, 32'h1111_1111, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFF8, 1'b0};
    tbl[4]  = '{2'b11, 1'b0, 1'b0, 32'h1111_1111, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0078, 1'b0};
    tbl[5]  = '{2'b00, 1'b1, 1'b1, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7FFF_FFF0, 32'h7FFF_FFFF, 1'b1};
    tbl[6]  = '{2'b00, 1'b1, 1'b0, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7FFF_FFF0, 32'h8000_FBF4, 1'b1};
    tbl[7]  = '{2'b01, 1'b1, 1'b1, 32'h0101_0101, 32'h0101_0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    tbl[8]  = '{2'b01, 1'b1, 1'b0, 32'h0101_0101, 32'h0101_0101, 32'hFFFF_FFFF, 32'h0000_0003, 1'b1};
    tbl[9]  = '{2'b00, 1'b1, 1'b1, 32'h8080_8080, 32'h7F7F_7F7F, 32'h8000_0000, 32'h8000_0000, 1'b1};
    tbl[10] = '{2'b00, 1'b1, 1'b0, 32'h8080_8080, 32'h7F7F_7F7F, 32'h8000_0000, 32'h7FFF_0200, 1'b1};
    tbl[11] = '{2'b00, 1'b1, 1'b1, 32'h0403_0201, 32'h0101_0101, 32'h0000_0010, 32'h0000_001A, 1'b0};
    tbl[12] = '{2'b00, 1'b0, 1'b1, 32'h8080_8080, 32'h8080_8080, 32'h0000_0000, 32'h0001_0000, 1'b0};
    tbl[13] = '{2'b10, 1'b0, 1'b0, 32'h8888_8888, 32'h8888_8888, 32'h0000_0000, 32'h0000_0200, 1'b0};
    tbl[14] = '{2'b11, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_F000, 32'hFFFF_F708, 1'b0};
    tbl[15] = '{2'b00, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};

    valid_in = 1'b0; op_mode = '0; op_acc = 1'b0; op_sat = 1'b0;
    a_in = '0; b_in = '0; c_in = '0; tag_in = '0; ready_out = 1'b1;
    v_valid_in = 1'b0; v_op_mode = '0; v_op_acc = 1'b0; v_op_sat = 1'b0;
    v_a_in = '0; v_b_in = '0; v_c_in = '0; v_tag_in = '0; v_ready_out = 1'b1;

    // Clock/reset
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_out", valid_out, 0);
    check("reset_ready_in", ready_in, 1);
    check("reset_data_out", data_out, 0);
    check("reset_ovf_out", ovf_out, 0);
    check("reset_tag_out", tag_out, 0);
    check("reset_valid_out64", v_valid_out, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_ready_in", ready_in, 1);

    // Directed vectors, all lanes identical
    for (int i = 0; i < 16; i++) begin
      a = {NL{tbl[i].a}};
      b = {NL{tbl[i].b}};
      c = {NL{tbl[i].c}};
      e = {{NL{tbl[i].exp_d}}, {NL{tbl[i].exp_o}}, 8'(i + 16)};
      send(tbl[i].mode, tbl[i].acc, tbl[i].sat, a, b, c, 8'(i + 16), e);
      if (i == 0) measure_latency("latency_first");
    end
    drain();

    // Backpressure: 5 back-to-back beats, output stalled 3 cycles after the first result
    base = out_cnt;
    fork
      begin
        for (int i = 0; i < 5; i++) send_rand(8'(8'hA0 + i));
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!valid_out && n < 50);
        check("bp_first_output", valid_out, 1);
        @(posedge clk);
        #1;
        ready_out = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_ready_in", ready_in, 0);
          check("stall_valid_out", valid_out, 1);
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
      end
    join
    drain();
    check("bp_count", out_cnt - base, 5);

    // Reset with two beats in flight
    send_rand(8'hB0);
    send_rand(8'hB1);
    check("pre_reset_valid_out", valid_out, 1);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_valid_out", valid_out, 0);
    check("async_reset_ready_in", ready_in, 1);
    exp_q.delete();
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_reset_idle", valid_out, 0);
    end
    @(posedge clk);
    #1;
    send_rand(8'hC0);
    measure_latency("latency_after_reset");
    drain();

    // Random traffic with random output backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_rand(8'(i));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          ready_out = ($urandom_range(0, 3) != 0);
        end
        ready_out = 1'b1;
      end
    join
    drain();

    // XLEN=64, LATENCY=1 instance: extension of the 32-bit result into the upper word
    send64("x64_s8", 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0101_0101, 32'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send64("x64_u8", 2'b01, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0101_0101, 32'h0, 64'h0000_0000_0000_03FC, 1'b0);
    send64("x64_sat_hi", 2'b00, 1'b1, 1'b1, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7FFF_FFF0,
           64'h0000_0000_7FFF_FFFF, 1'b1);
    send64("x64_sat_lo", 2'b00, 1'b1, 1'b1, 32'h8080_8080, 32'h7F7F_7F7F, 32'h8000_0000,
           64'hFFFF_FFFF_8000_0000, 1'b1);
    send64("x64_u_wrap", 2'b01, 1'b1, 1'b0, 32'h0101_0101, 32'h0101_0101, 32'hFFFF_FFFF,
           64'h0000_0000_0000_0003, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
